// File: rtl/switch_debounce_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the slide-switch controller.
// master: interconnect side, slave: switch_debounce_irq_ctrl.
interface switch_debounce_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/switch_debounce_irq_ctrl.sv
// DE2 slide-switch bank controller: 2-FF synchroniser, optional prescaled
// 3-sample debounce, per-bit edge capture (sticky, W1C) and a maskable
// level interrupt, exposed as an Avalon-MM slave.
//
// Build option: define SWITCH_DEBOUNCE_EN to include the prescaler and the
// 3-sample debounce. Without it, debounced follows the synchroniser output
// directly and DEBOUNCE_CYCLES/CNT_W only take part in the config check.
//
// Register map (word address):
//   0 DATA  RO    debounced
//   1 MASK  RW    irq_mask
//   2 MODE  RW    edge_mode (00 rising, 01 falling, 1x both)
//   3 EDGE  R/W1C edge_cap
module switch_debounce_irq_ctrl #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  switch_debounce_irq_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  // Reject configurations the datapath cannot represent.
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || CNT_W < 1 || CNT_W > 32 ||
      (64'(1) << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_cfg_check
    $error("switch_debounce_irq_ctrl: illegal WIDTH/DEBOUNCE_CYCLES/CNT_W");
  end

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       edge_mode;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c_clear;
  logic             wr_en;
  logic [31:0]      rd_next;

  // Two-stage synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] presc;
  logic             tick;
  logic [WIDTH-1:0] hist_1;
  logic [WIDTH-1:0] hist_2;
  logic [WIDTH-1:0] stable_hi;
  logic [WIDTH-1:0] stable_lo;

  assign tick = (presc == PRESC_LAST);

  // Free-running prescaler, 0..DEBOUNCE_CYCLES-1, one-clk tick on the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // The 3-deep window is {sync, hist_1, hist_2} at the tick: the sample being
  // shifted in plus the two previous ones, so agreement and acceptance land on
  // the same tick edge.
  assign stable_hi = sync & hist_1 & hist_2;
  assign stable_lo = ~(sync | hist_1 | hist_2);

  // Sample history shift and debounced update on each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_1    <= '0;
      hist_2    <= '0;
      debounced <= '0;
    end else if (tick) begin
      hist_1    <= sync;
      hist_2    <= hist_1;
      debounced <= (debounced | stable_hi) & ~stable_lo;
    end
  end
`else
  assign debounced = sync;
`endif

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign rise      = debounced & ~debounced_d;
  assign fall      = ~debounced & debounced_d;
  assign w1c_clear = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Qualify debounced changes against the registered edge mode.
  always_comb begin
    edge_hit = '0;
    if (edge_mode[1]) begin
      edge_hit = rise | fall;
    end else if (edge_mode[0]) begin
      edge_hit = fall;
    end else begin
      edge_hit = rise;
    end
  end

  // Edge history and sticky capture; a new edge beats a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_d <= '0;
      edge_cap    <= '0;
    end else begin
      debounced_d <= debounced;
      edge_cap    <= (edge_cap & ~w1c_clear) | edge_hit;
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      edge_mode <= '0;
    end else if (wr_en) begin
      if (bus.address == 2'd1) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      if (bus.address == 2'd2) begin
        edge_mode <= bus.writedata[1:0];
      end
    end
  end

  // Read mux; unused high bits read as zero.
  always_comb begin
    rd_next = '0;
    unique case (bus.address)
      2'd0: rd_next = 32'(debounced);
      2'd1: rd_next = 32'(irq_mask);
      2'd2: rd_next = {30'd0, edge_mode};
      2'd3: rd_next = 32'(edge_cap);
      default: rd_next = '0;
    endcase
  end

  // Registered read data, one-clk latency, no wait states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule
